// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types for the instruction/data BRAM arbiter.
// Access-size encodings and the response-tracking states.
package imem_dmem_arbiter_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    DM_PEND,
    IF_PEND,
    IF_HOLD,
    DM_HOLD
  } state_t;

endpackage

// File: rtl/imem_dmem_arbiter_store_lane_align.sv
// Byte-lane enables and replicated write data for a store.
// Purely combinational; offset assumed already alignment-checked.
module store_lane_align
  import imem_dmem_arbiter_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata
);

  always_comb begin
    be         = 4'b0000;
    lane_wdata = wdata;
    unique case (1'b1)
      (size == SIZE_B): begin
        be         = 4'b0001 << off;
        lane_wdata = {4{wdata[7:0]}};
      end
      (size == SIZE_H): begin
        be         = 4'b0011 << off;
        lane_wdata = {2{wdata[15:0]}};
      end
      (size == SIZE_W): begin
        be         = 4'b1111;
        lane_wdata = wdata;
      end
      default: begin
        be         = 4'b0000;
        lane_wdata = wdata;
      end
    endcase
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Single-port BRAM shared by fetch and data ports, data first.
// Tracks the outstanding read and holds fetched words under stall.
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int AW = 12,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_valid,
  output logic          stall_f,
  input  logic          hold_d,
  input  logic          flush_d,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW+1:0] dm_addr,
  input  logic [1:0]    dm_size,
  input  logic [31:0]   dm_wdata,
  output logic [31:0]   dm_rdata,
  output logic          dm_valid,
  output logic          dm_misalign,
  output logic          bram_en,
  output logic [3:0]    bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [31:0]   bram_wdata,
  input  logic [31:0]   bram_rdata,
  output logic [CW-1:0] conflict_cnt
);

  state_t      state;
  state_t      state_nx;
  logic [31:0] hold_q;
  logic        misalign;
  logic        dm_grant;
  logic        ld_grant;
  logic        if_grant;
  logic        hold_st;
  logic        if_block;
  logic        keep;
  logic [3:0]  lane_be;

  store_lane_align u_align (
    .size       (dm_size),
    .off        (dm_addr[1:0]),
    .wdata      (dm_wdata),
    .be         (lane_be),
    .lane_wdata (bram_wdata)
  );

  always_comb begin
    misalign = (dm_size == SIZE_H && dm_addr[0])
            || (dm_size == SIZE_W && dm_addr[1:0] != 2'b00)
            || (dm_size == 2'b11);
    hold_st  = (state == IF_HOLD) || (state == DM_HOLD);
    if_block = (hold_st && (hold_d || flush_d))
            || (state == IF_PEND && hold_d);
    dm_grant = reset && dm_req && !misalign;
    ld_grant = dm_grant && !dm_we;
    if_grant = reset && if_req && !dm_req && !if_block;
    stall_f  = if_req && !if_grant;
    keep     = (hold_st || state == IF_PEND) && hold_d && !flush_d;
  end

  assign dm_misalign = dm_req && misalign;
  assign bram_en     = dm_grant || if_grant;
  assign bram_addr   = dm_grant ? dm_addr[AW+1:2] : if_addr;
  assign bram_we     = (dm_grant && dm_we) ? lane_be : 4'b0000;

  always_comb begin
    dm_valid = (state == DM_PEND) || (state == DM_HOLD);
    dm_rdata = dm_valid ? bram_rdata : 32'h0;
    if_valid = (state == IF_PEND || hold_st) && !flush_d;
    if_rdata = 32'h0;
    if (if_valid)
      if_rdata = (state == IF_PEND) ? bram_rdata : hold_q;
  end

  // A held instruction survives an interleaved load via DM_HOLD
  always_comb begin
    state_nx = IDLE;
    if (keep)
      state_nx = ld_grant ? DM_HOLD : IF_HOLD;
    else if (ld_grant)
      state_nx = DM_PEND;
    else if (if_grant)
      state_nx = IF_PEND;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      hold_q       <= 32'h0;
      conflict_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IF_PEND && hold_d && !flush_d)
        hold_q <= bram_rdata;
      if (stall_f && conflict_cnt != '1)
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule
